// File: rtl/scoot_bot_ctrl.sv
// scoot_bot_ctrl: light-following motor controller for one scoot-bot.
// Keeps a short sensor history and scores each direction from it.
// The FSM picks a classic, seek or flee motor command and holds it for a fixed time.
// After a run of dark cycles it wanders by rotating a one-hot drive pattern.
module scoot_bot_ctrl #(
    parameter int NDIR         = 4,
    parameter int HIST         = 2,
    parameter int HOLD         = 3,
    parameter int WANDER_TICKS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NDIR-1:0]         light,
    input  logic [1:0]              mode_sel,
    output logic [NDIR-1:0]         motor,
    output logic [1:0]              state,
    output logic [$clog2(NDIR)-1:0] dir_idx,
    output logic                    valid
);

    localparam int IDX_W   = $clog2(NDIR);
    localparam int SCORE_W = $clog2(HIST + 2);
    localparam int HOLD_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int DARK_W  = (WANDER_TICKS > 1) ? $clog2(WANDER_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_TRACK  = 2'b01,
        S_HOLD   = 2'b10,
        S_WANDER = 2'b11
    } stateT;

    stateT              stateR;
    logic [NDIR-1:0]    hist [HIST];
    logic [HOLD_W-1:0]  holdCnt;
    logic [DARK_W-1:0]  darkCnt;
    logic [IDX_W-1:0]   dirIdx;

    logic [SCORE_W-1:0] score [NDIR];
    logic [SCORE_W-1:0] bestScore;
    logic [IDX_W-1:0]   bestIdx;
    logic [IDX_W-1:0]   fleeIdx;
    logic [NDIR-1:0]    classicMotor;
    logic               anyScore;

    function automatic logic [NDIR-1:0] oneHot(input logic [IDX_W-1:0] idx);
        logic [NDIR-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Sensor history shift register; runs in every state, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < HIST; k++) hist[k] <= '0;
        end else begin
            hist[0] <= light;
            for (int k = 1; k < HIST; k++) hist[k] <= hist[k-1];
        end
    end

    // Per-direction scores, strongest direction (lowest index wins ties),
    // its opposite, and the classic rotate-OR pattern
    always_comb begin
        int tmp;
        logic [SCORE_W-1:0] sc;
        bestIdx      = '0;
        bestScore    = '0;
        classicMotor = '0;
        for (int i = 0; i < NDIR; i++) begin
            sc = SCORE_W'(light[i]);
            for (int k = 0; k < HIST; k++) sc = sc + SCORE_W'(hist[k][i]);
            score[i] = sc;
            if (sc > bestScore) begin
                bestScore = sc;
                bestIdx   = IDX_W'(i);
            end
            classicMotor[i] = light[i] | hist[0][(i + 1) % NDIR];
        end
        anyScore = (bestScore != '0);
        tmp      = int'(bestIdx) + NDIR / 2;
        if (tmp >= NDIR) tmp = tmp - NDIR;
        fleeIdx  = IDX_W'(tmp);
    end

    // Behaviour FSM with registered motor drive and direction index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateR  <= S_IDLE;
            motor   <= '0;
            dirIdx  <= '0;
            holdCnt <= '0;
            darkCnt <= '0;
        end else begin
            case (stateR)
                S_IDLE: begin
                    if (|light) begin
                        stateR  <= S_TRACK;
                        darkCnt <= '0;
                    end else if (darkCnt == DARK_W'(WANDER_TICKS - 1)) begin
                        stateR  <= S_WANDER;
                        motor   <= oneHot('0);
                        darkCnt <= '0;
                    end else begin
                        darkCnt <= darkCnt + 1'b1;
                    end
                end
                S_TRACK: begin
                    darkCnt <= '0;
                    if (!anyScore) begin
                        stateR <= S_IDLE;
                    end else begin
                        case (mode_sel)
                            2'b00: begin
                                motor  <= classicMotor;
                                dirIdx <= '0;
                            end
                            2'b10: begin
                                motor  <= oneHot(fleeIdx);
                                dirIdx <= fleeIdx;
                            end
                            default: begin
                                motor  <= oneHot(bestIdx);
                                dirIdx <= bestIdx;
                            end
                        endcase
                        holdCnt <= HOLD_W'(HOLD - 1);
                        stateR  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    darkCnt <= '0;
                    if (holdCnt == '0) begin
                        motor  <= '0;
                        stateR <= (|light) ? S_TRACK : S_IDLE;
                    end else begin
                        holdCnt <= holdCnt - 1'b1;
                    end
                end
                S_WANDER: begin
                    darkCnt <= '0;
                    if (|light) begin
                        motor  <= '0;
                        stateR <= S_TRACK;
                    end else begin
                        motor <= {motor[NDIR-2:0], motor[NDIR-1]};
                    end
                end
                default: begin
                    stateR <= S_IDLE;
                    motor  <= '0;
                end
            endcase
        end
    end

    assign state   = stateR;
    assign dir_idx = dirIdx;
    assign valid   = (|motor) && ((stateR == S_HOLD) || (stateR == S_WANDER));

endmodule

// File: tb/tb_scoot_bot_ctrl.sv
// Testbench for scoot_bot_ctrl: directed scenarios followed by randomized
// light/mode/reset stimulus, all checked against a behavioural model.
module tb_scoot_bot_ctrl;

    localparam int NDIR         = 4;
    localparam int HIST         = 2;
    localparam int HOLD         = 3;
    localparam int WANDER_TICKS = 8;

    logic            clk;
    logic            rst_n;
    logic [NDIR-1:0] light;
    logic [1:0]      mode_sel;
    logic [NDIR-1:0] motor;
    logic [1:0]      state;
    logic [1:0]      dir_idx;
    logic            valid;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: phase 0 idle, 1 track, 2 hold, 3 wander
    int mState, mMotor, mDir, mHoldLeft, mDark, mPos;
    bit mJustReset;
    int histQ[$];

    scoot_bot_ctrl #(
        .NDIR(NDIR), .HIST(HIST), .HOLD(HOLD), .WANDER_TICKS(WANDER_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .light(light), .mode_sel(mode_sel),
        .motor(motor), .state(state), .dir_idx(dir_idx), .valid(valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic modelStep(input logic rn, input logic [NDIR-1:0] l, input logic [1:0] m);
        int sc[NDIR];
        int total, best, tgt, bit0;
        mJustReset = 1'b0;
        if (!rn) begin
            mState = 0; mMotor = 0; mDir = 0; mHoldLeft = 0; mDark = 0; mPos = 0;
            histQ.delete();
            for (int k = 0; k < HIST; k++) histQ.push_back(0);
            mJustReset = 1'b1;
        end else begin
            total = 0;
            for (int i = 0; i < NDIR; i++) begin
                sc[i] = int'(l[i]);
                foreach (histQ[k]) sc[i] += (histQ[k] >> i) & 1;
                total += sc[i];
            end
            case (mState)
                0: begin
                    if (l != 0) begin
                        mState = 1;
                        mDark  = 0;
                    end else begin
                        mDark++;
                        if (mDark == WANDER_TICKS) begin
                            mState = 3; mPos = 0; mMotor = 1; mDark = 0;
                        end
                    end
                end
                1: begin
                    if (total == 0) begin
                        mState = 0;
                    end else begin
                        if (m == 2'b00) begin
                            mMotor = 0;
                            for (int i = 0; i < NDIR; i++) begin
                                bit0 = int'(l[i]) | ((histQ[0] >> ((i + 1) % NDIR)) & 1);
                                mMotor += bit0 << i;
                            end
                            mDir = 0;
                        end else begin
                            best = 0;
                            for (int i = 1; i < NDIR; i++) if (sc[i] > sc[best]) best = i;
                            tgt    = (m == 2'b10) ? (best + NDIR / 2) % NDIR : best;
                            mMotor = 1 << tgt;
                            mDir   = tgt;
                        end
                        mHoldLeft = HOLD;
                        mState    = 2;
                    end
                end
                2: begin
                    mHoldLeft--;
                    if (mHoldLeft == 0) begin
                        mMotor = 0;
                        mState = (l != 0) ? 1 : 0;
                    end
                end
                default: begin
                    if (l != 0) begin
                        mMotor = 0;
                        mState = 1;
                    end else begin
                        mPos   = (mPos + 1) % NDIR;
                        mMotor = 1 << mPos;
                    end
                end
            endcase
            histQ.push_front(int'(l));
            void'(histQ.pop_back());
        end
    endtask

    // Apply inputs for one clock, update the model and compare after the edge
    task automatic cycle(input logic rn, input logic [NDIR-1:0] l, input logic [1:0] m);
        rst_n = rn; light = l; mode_sel = m;
        @(posedge clk);
        modelStep(rn, l, m);
        #1;
        checkVal("state", int'(state), mState);
        checkVal("motor", int'(motor), mMotor);
        checkVal("valid", int'(valid), (mMotor != 0 && mState >= 2) ? 1 : 0);
        if (mState == 2 || mJustReset) checkVal("dir_idx", int'(dir_idx), mDir);
    endtask

    initial begin
        int darkLeft;
        int r;
        logic [NDIR-1:0] l;
        rst_n = 1'b0; light = '0; mode_sel = 2'b00;
        mState = 0; mMotor = 0; mDir = 0; mHoldLeft = 0; mDark = 0; mPos = 0;
        mJustReset = 1'b0;
        for (int k = 0; k < HIST; k++) histQ.push_back(0);

        // Reset with all sensors lit
        cycle(1'b0, 4'b1111, 2'b00);
        cycle(1'b0, 4'b1111, 2'b00);
        checkVal("rst_state", int'(state), 0);
        checkVal("rst_motor", int'(motor), 0);
        checkVal("rst_dir", int'(dir_idx), 0);

        // Seek towards direction 2
        cycle(1'b1, 4'b0100, 2'b01);
        checkVal("seek_track", int'(state), 1);
        for (int c = 0; c < HOLD; c++) begin
            cycle(1'b1, 4'b0100, 2'b01);
            checkVal("seek_hold", int'(state), 2);
            checkVal("seek_motor", int'(motor), 4);
            checkVal("seek_dir", int'(dir_idx), 2);
            checkVal("seek_valid", int'(valid), 1);
        end
        cycle(1'b1, 4'b0100, 2'b01);
        checkVal("seek_retrack", int'(state), 1);

        // Reset arriving in the middle of HOLD
        cycle(1'b1, 4'b0100, 2'b01);
        cycle(1'b0, 4'b1111, 2'b01);
        cycle(1'b0, 4'b1111, 2'b01);
        checkVal("midhold_rst_state", int'(state), 0);
        checkVal("midhold_rst_valid", int'(valid), 0);

        // Flee away from direction 1
        cycle(1'b1, 4'b0010, 2'b10);
        cycle(1'b1, 4'b0010, 2'b10);
        checkVal("flee_motor", int'(motor), 8);
        checkVal("flee_dir", int'(dir_idx), 3);
        cycle(1'b0, 4'b0000, 2'b00);

        // Tie between current light and history resolves to the lower index
        cycle(1'b1, 4'b0001, 2'b01);
        cycle(1'b1, 4'b0010, 2'b01);
        checkVal("tie_motor", int'(motor), 1);
        checkVal("tie_dir", int'(dir_idx), 0);
        cycle(1'b0, 4'b0000, 2'b00);

        // Classic rotate-OR
        cycle(1'b1, 4'b0100, 2'b00);
        cycle(1'b1, 4'b0001, 2'b00);
        checkVal("classic_motor", int'(motor), 3);
        cycle(1'b1, 4'b0000, 2'b00);
        cycle(1'b1, 4'b0000, 2'b00);
        checkVal("classic_held", int'(motor), 3);
        cycle(1'b1, 4'b0000, 2'b00);
        checkVal("classic_exit", int'(state), 0);
        cycle(1'b0, 4'b0000, 2'b00);

        // Wander after a dark run, then light ends it
        for (int c = 0; c < WANDER_TICKS; c++) cycle(1'b1, 4'b0000, 2'b00);
        checkVal("wander_state", int'(state), 3);
        checkVal("wander_m0", int'(motor), 1);
        for (int c = 1; c <= NDIR; c++) begin
            cycle(1'b1, 4'b0000, 2'b00);
            checkVal("wander_rot", int'(motor), 1 << (c % NDIR));
        end
        cycle(1'b1, 4'b1000, 2'b00);
        checkVal("wander_exit_state", int'(state), 1);
        checkVal("wander_exit_motor", int'(motor), 0);

        // Randomized traffic with dark bursts and occasional resets
        darkLeft = 0;
        for (int n = 0; n < 3000; n++) begin
            if (darkLeft > 0) begin
                l = '0;
                darkLeft--;
            end else begin
                r = int'($urandom_range(0, 15));
                if (r == 0) darkLeft = int'($urandom_range(4, 14));
                l = (r < 5) ? '0 : NDIR'($urandom_range(0, 15));
            end
            cycle(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0, l, 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
